// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds one shared UART transmitter from NUM_REQ byte
// producers, holding the grant across multi-byte packets until req_last.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int PAYLOAD_BITS = 8,
  parameter int BUSY_WAIT    = 4
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            uart_tx_en,
  output logic [PAYLOAD_BITS-1:0]         uart_tx_data,
  input  logic                            uart_tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            locked
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BUSY_WAIT + 1);

  typedef enum logic [1:0] {ARB, ISSUE, WAIT_HI, WAIT_LO} state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [IDX_W-1:0]        rr_ptr_q;
  logic [CNT_W-1:0]        wait_cnt_q;

  logic                    win_found;
  logic [IDX_W-1:0]        win_idx;
  logic [PAYLOAD_BITS-1:0] win_data;
  logic                    win_last;
  logic                    accept;

  // NUM_REQ need not be a power of two, so wrap with an explicit modulo.
  function automatic logic [IDX_W-1:0] rr_add(input logic [IDX_W-1:0] base, input int offset);
    int sum;
    sum = (int'(base) + offset) % NUM_REQ;
    return IDX_W'(sum);
  endfunction

  // Scan from the highest offset down so the requester closest to rr_ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    if (locked) begin
      win_found = req_valid[grant_id];
      win_idx   = grant_id;
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (req_valid[rr_add(rr_ptr_q, k)]) begin
          win_found = 1'b1;
          win_idx   = rr_add(rr_ptr_q, k);
        end
      end
    end
  end

  always_comb begin
    win_data = '0;
    win_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_data = req_data[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        win_last = req_last[i];
      end
    end
  end

  // A transmitter still busy in ARB (e.g. after a mid-frame reset) blocks acceptance.
  assign accept = (state_q == ARB) && !uart_tx_busy && win_found;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ARB;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB: begin
        if (accept) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (uart_tx_busy) begin
          state_d = WAIT_LO;
        end else if (wait_cnt_q == CNT_W'(BUSY_WAIT - 1)) begin
          state_d = ARB;
        end
      end
      WAIT_LO: begin
        if (!uart_tx_busy) begin
          state_d = ARB;
        end
      end
      default: begin
        state_d = ARB;
      end
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[win_idx] = 1'b1;
    end
    uart_tx_en = (state_q == ISSUE);
  end

  // The pointer moves only on a packet's last byte so a locked owner keeps priority.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      uart_tx_data <= '0;
      grant_id     <= '0;
      locked       <= 1'b0;
      rr_ptr_q     <= '0;
      wait_cnt_q   <= '0;
    end else begin
      if (accept) begin
        uart_tx_data <= win_data;
        grant_id     <= win_idx;
        locked       <= ~win_last;
        if (win_last) begin
          rr_ptr_q <= rr_add(win_idx, 1);
        end
      end
      if (state_q == ISSUE) begin
        wait_cnt_q <= '0;
      end else if ((state_q == WAIT_HI) && !uart_tx_busy) begin
        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule
